// File: rtl/word_aligner_pkg.sv
// Shared definitions for the bitslip word aligner: lane FSM states and default
// training pattern / lock thresholds.
package word_aligner_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } lane_state_t;

    localparam logic [9:0] DEFAULT_PATTERN           = 10'b0001111111;
    localparam int         DEFAULT_MATCHES_FOR_LOCK  = 8;
    localparam int         DEFAULT_MISSES_FOR_UNLOCK = 4;

endpackage

// File: rtl/word_aligner_lane.sv
// One aligner lane: previous-word register, barrel selection of the aligned
// word, and the SEARCH/CONFIRM/LOCKED training FSM with its counters.
module word_aligner_lane
    import word_aligner_pkg::*;
#(
    parameter int                    WORD_WIDTH        = 10,
    parameter logic [WORD_WIDTH-1:0] TRAINING_PATTERN  = DEFAULT_PATTERN,
    parameter int                    MATCHES_FOR_LOCK  = DEFAULT_MATCHES_FOR_LOCK,
    parameter int                    MISSES_FOR_UNLOCK = DEFAULT_MISSES_FOR_UNLOCK
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic                          i_training,
    input  logic [WORD_WIDTH-1:0]         i_word,
    output logic [WORD_WIDTH-1:0]         o_word,
    output logic [$clog2(WORD_WIDTH)-1:0] o_offset,
    output logic                          o_locked,
    output logic                          o_wrapped,
    output logic [1:0]                    o_state
);

    localparam int OW  = $clog2(WORD_WIDTH);
    localparam int MCW = $clog2(MATCHES_FOR_LOCK + 1);
    localparam int XCW = $clog2(MISSES_FOR_UNLOCK + 1);
    localparam logic [OW-1:0]  OFFSET_MAX   = OW'(WORD_WIDTH - 1);
    localparam logic [MCW-1:0] MATCH_LIMIT  = MCW'(MATCHES_FOR_LOCK);
    localparam logic [XCW-1:0] MISS_LIMIT   = XCW'(MISSES_FOR_UNLOCK);

    logic [WORD_WIDTH-1:0] r_prev;
    logic [WORD_WIDTH-1:0] r_out;
    logic [OW-1:0]         r_offset;
    lane_state_t           r_state;
    logic [MCW-1:0]        r_match_count;
    logic [XCW-1:0]        r_miss_count;
    logic                  r_wrapped;

    logic [2*WORD_WIDTH-1:0] w_concat;
    logic [WORD_WIDTH-1:0]   w_aligned;
    logic                    w_match;
    logic                    w_wrap;
    logic [OW-1:0]           w_offset_next;
    logic [MCW-1:0]          w_match_next;
    logic [XCW-1:0]          w_miss_next;

    // The current word sits above the previous one; offset 0 selects the previous word.
    assign w_concat      = {i_word, r_prev};
    assign w_aligned     = w_concat[r_offset +: WORD_WIDTH];
    assign w_match       = (w_aligned == TRAINING_PATTERN);
    assign w_wrap        = (r_offset == OFFSET_MAX);
    assign w_offset_next = w_wrap ? '0 : r_offset + 1'b1;
    assign w_match_next  = (r_state == ST_CONFIRM) ? r_match_count + 1'b1 : MCW'(1);
    assign w_miss_next   = r_miss_count + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev        <= '0;
            r_out         <= '0;
            r_offset      <= '0;
            r_state       <= ST_SEARCH;
            r_match_count <= '0;
            r_miss_count  <= '0;
            r_wrapped     <= 1'b0;
        end else if (i_valid) begin
            r_prev <= i_word;
            r_out  <= w_aligned;
            if (i_training) begin
                case (r_state)
                    ST_SEARCH, ST_CONFIRM: begin
                        if (w_match) begin
                            if (w_match_next == MATCH_LIMIT) begin
                                r_state       <= ST_LOCKED;
                                r_match_count <= '0;
                                r_miss_count  <= '0;
                            end else begin
                                r_state       <= ST_CONFIRM;
                                r_match_count <= w_match_next;
                            end
                        end else begin
                            r_state       <= ST_SEARCH;
                            r_match_count <= '0;
                            r_offset      <= w_offset_next;
                            if (w_wrap) r_wrapped <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            r_miss_count <= '0;
                        end else if (w_miss_next == MISS_LIMIT) begin
                            r_state       <= ST_SEARCH;
                            r_miss_count  <= '0;
                            r_match_count <= '0;
                            r_offset      <= w_offset_next;
                            if (w_wrap) r_wrapped <= 1'b1;
                        end else begin
                            r_miss_count <= w_miss_next;
                        end
                    end
                    default: r_state <= ST_SEARCH;
                endcase
            end
        end
    end

    assign o_word    = r_out;
    assign o_offset  = r_offset;
    assign o_locked  = (r_state == ST_LOCKED);
    assign o_wrapped = r_wrapped;
    assign o_state   = r_state;

endmodule

// File: rtl/bitslip_word_aligner.sv
// Multi-lane bitslip word aligner: slices the lane buses, registers the shared
// valid and reduces the per-lane lock flags.
module bitslip_word_aligner
    import word_aligner_pkg::*;
#(
    parameter int                    WORD_WIDTH        = 10,
    parameter int                    CHANNELS          = 1,
    parameter logic [WORD_WIDTH-1:0] TRAINING_PATTERN  = DEFAULT_PATTERN,
    parameter int                    MATCHES_FOR_LOCK  = DEFAULT_MATCHES_FOR_LOCK,
    parameter int                    MISSES_FOR_UNLOCK = DEFAULT_MISSES_FOR_UNLOCK
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [CHANNELS*WORD_WIDTH-1:0]         input_word,
    input  logic                                   input_valid,
    input  logic                                   training_enable,
    output logic [CHANNELS*WORD_WIDTH-1:0]         output_word,
    output logic                                   output_valid,
    output logic [CHANNELS*$clog2(WORD_WIDTH)-1:0] offset,
    output logic [CHANNELS-1:0]                    locked,
    output logic                                   all_locked,
    output logic [CHANNELS-1:0]                    search_wrapped,
    output logic [CHANNELS*2-1:0]                  debug_state
);

    localparam int OW = $clog2(WORD_WIDTH);

    logic r_output_valid;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        word_aligner_lane #(
            .WORD_WIDTH       (WORD_WIDTH),
            .TRAINING_PATTERN (TRAINING_PATTERN),
            .MATCHES_FOR_LOCK (MATCHES_FOR_LOCK),
            .MISSES_FOR_UNLOCK(MISSES_FOR_UNLOCK)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .i_valid   (input_valid),
            .i_training(training_enable),
            .i_word    (input_word[g*WORD_WIDTH +: WORD_WIDTH]),
            .o_word    (output_word[g*WORD_WIDTH +: WORD_WIDTH]),
            .o_offset  (offset[g*OW +: OW]),
            .o_locked  (locked[g]),
            .o_wrapped (search_wrapped[g]),
            .o_state   (debug_state[g*2 +: 2])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_output_valid <= 1'b0;
        else        r_output_valid <= input_valid;
    end

    assign output_valid = r_output_valid;
    assign all_locked   = &locked;

endmodule
